div_sched: RTL and testbench
============================

# div_sched

Operand scheduler that sits directly upstream of the 8-bit / 5-bit divider and also collects the divider's results. It buffers incoming operand pairs in a FIFO and issues at most one pair per cycle to the divider. Divide-by-zero requests are handled internally and never issued. Results are returned in request order, carrying each request's tag, through a 2-entry output buffer with valid/ready back-pressure.

## Interface
Parameters:
- DEPTH, 4: operand FIFO depth; power of 2, ≥2.
- TAG_W, 3: request tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-high (named per codebase convention; asserted = 1).
- in_valid  in  1  request valid.
- in_ready  out  1  request accept; the handshake completes when in_valid && in_ready.
- in_a  in  8  dividend.
- in_b  in  5  divisor.
- in_tag  in  TAG_W  request tag.
- div_a  out  8  to divider i_a.
- div_b  out  5  to divider i_b.
- div_in_valid  out  1  to divider i_in_valid.
- div_q  in  8  from divider o_q.
- div_r  in  5  from divider o_r.
- div_out_valid  in  1  from divider o_out_valid.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_q  out  8  quotient.
- res_r  out  5  remainder.
- res_tag  out  TAG_W  tag of the originating request.
- res_dz  out  1  divide-by-zero flag.
- err  out  1  sticky protocol error.

## Operation
- **Operand FIFO:** DEPTH entries of {a, b, tag}, with pointers of log2(DEPTH) bits that wrap.
  - Count range is 0..DEPTH.
  - in_ready = (count < DEPTH) && !rst_n; there is no same-cycle pop credit.
  - A simultaneous push and pop leaves the count unchanged.
- **Divider contract:** the divider has exactly 1 cycle of latency. A pair driven with div_in_valid=1 in cycle N returns with div_out_valid=1 in cycle N+1.
- **Issue condition:** issue = fifo_nonempty && (res_count + inflight − (res_valid && res_ready)) ≤ 1.
  - This credit rule guarantees the result buffer never overflows, because the divider cannot stall.
- **Issue of a normal request (b ≠ 0):**
  - div_in_valid=1, div_a/div_b driven from the FIFO head; the FIFO pops.
  - Flight register is loaded with inflight=1, dz=0, tag.
- **Issue of a divide-by-zero request (b = 0):**
  - div_in_valid=0; the FIFO pops.
  - Flight register is loaded with inflight=1, dz=1, tag.
  - The request takes the same 1-cycle slot as a normal request, so ordering is preserved.
- **When not issuing:** div_in_valid=0 and div_a/div_b=0.
- **Collect stage (cycle after issue):**
  - inflight && !dz: push {div_q, div_r, tag, 0} into the result buffer.
  - inflight && dz: push {8'hFF, 5'h00, tag, 1}.
- **Error detection:** err is set if div_out_valid disagrees with (inflight && !dz). That covers a spurious valid, and a missing valid (in which case the entry is still pushed with the captured div_q/div_r). err is cleared only by reset.
- **Result buffer:** 2-entry FIFO. res_valid = res_count ≠ 0; head fields drive res_q, res_r, res_tag and res_dz.
  - Push and pop in the same cycle are both allowed.
  - Outputs hold stable while res_valid && !res_ready.
- **Reset (rst_n=1 at a clock edge):**
  - Clears both FIFOs, the flight register and err.
  - While rst_n=1: in_ready=0, div_in_valid=0, res_valid=0.
  - Cycle after release: in_ready=1; res_q, res_r, res_tag and res_dz read 0.
  - Reset mid-operation discards all buffered and in-flight requests; a div_out_valid arriving in the cycle after reset is ignored and does not set err.

## Timing
- Handshake at cycle 0 → FIFO write at the end of cycle 0 → earliest issue in cycle 1 → divider result and buffer push at the end of cycle 2 → res_valid in cycle 3. Minimum latency is 3 cycles.
- Throughput is 1 request/cycle sustained with in_valid=1 and res_ready=1.
- With res_ready=0: at most 2 results are buffered and no further issue occurs. The FIFO then fills, and in_ready drops after DEPTH further accepts.
- Ordering is strict FIFO; res_tag order equals in_tag order, including dz requests.
- All outputs except div_a, div_b, div_in_valid and in_ready come directly from registers.

## Test plan
- **Single request:** a=200, b=7, tag=5 at cycle 0 → div_in_valid in cycle 1 with div_a=200, div_b=7 → res_valid in cycle 3 with q=28, r=4, tag=5, dz=0.
- **Divide by zero:** a=55, b=0, tag=2 → div_in_valid stays 0 → res_valid in cycle 3 with q=8'hFF, r=0, tag=2, dz=1, err=0.
- **Streaming:** 16 back-to-back random pairs, with b=0 mixed in and res_ready=1 → one result per cycle, in order, matching a/b and a%b; in_ready stays 1.
- **Back-pressure:** res_ready=0 with continuous in_valid → 2 results buffered, DEPTH accepts, then in_ready=0. Releasing res_ready → all results drain in order with none lost.
- **Protocol error:** force div_out_valid=1 in a cycle with no issue → err=1 from the next cycle and stays set until reset.
- **Reset mid-stream:** assert rst_n with 3 requests queued and 1 in flight → no result is emitted afterward; in_ready=1 and res_valid=0 in the cycle after release; the next request completes normally.

Source files
------------

// File: rtl/div_sched.sv
// Operand scheduler for the 1-cycle 8/5 divider: queues requests, issues one per
// cycle under a result-buffer credit check, and returns tagged results in order.
module div_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [4:0]       in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [7:0]       div_a,
    output logic [4:0]       div_b,
    output logic             div_in_valid,
    input  logic [7:0]       div_q,
    input  logic [4:0]       div_r,
    input  logic             div_out_valid,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_q,
    output logic [4:0]       res_r,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_dz,
    output logic             err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] L_DEPTH = DEPTH[AW:0];

    typedef struct packed {
        logic [7:0]       a;
        logic [4:0]       b;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [7:0]       q;
        logic [4:0]       r;
        logic [TAG_W-1:0] tag;
        logic             dz;
    } res_t;

    req_t             r_fifo [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;

    logic             r_fl_vld;
    logic             r_fl_dz;
    logic [TAG_W-1:0] r_fl_tag;
    logic             r_rst_d;
    logic             r_err;

    res_t             r_hd;
    res_t             r_tl;
    logic             r_hd_vld;
    logic             r_tl_vld;

    req_t             w_head;
    logic             w_head_dz;
    logic             w_push;
    logic             w_issue;
    logic             w_res_pop;
    logic [2:0]       w_occ;
    logic [2:0]       w_room;
    res_t             w_res_new;
    res_t             w_n_hd;
    res_t             w_n_tl;
    logic             w_n_hd_vld;
    logic             w_n_tl_vld;

    assign in_ready  = (r_count < L_DEPTH) && !rst_n;
    assign w_push    = in_valid && in_ready;
    assign w_head    = r_fifo[r_rptr];
    assign w_head_dz = (w_head.b == 5'd0);
    assign w_res_pop = r_hd_vld && res_ready;

    // The divider cannot stall, so only issue when the result buffer is sure to
    // have a slot for this request one cycle from now.
    assign w_occ   = {2'b00, r_hd_vld} + {2'b00, r_tl_vld} + {2'b00, r_fl_vld};
    assign w_room  = 3'd1 + {2'b00, w_res_pop};
    assign w_issue = !rst_n && (r_count != '0) && (w_occ <= w_room);

    assign div_in_valid = w_issue && !w_head_dz;
    assign div_a        = div_in_valid ? w_head.a : 8'd0;
    assign div_b        = div_in_valid ? w_head.b : 5'd0;

    always_comb begin
        w_res_new     = '0;
        w_res_new.tag = r_fl_tag;
        if (r_fl_dz) begin
            w_res_new.q  = 8'hFF;
            w_res_new.r  = 5'd0;
            w_res_new.dz = 1'b1;
        end else begin
            w_res_new.q  = div_q;
            w_res_new.r  = div_r;
            w_res_new.dz = 1'b0;
        end
    end

    // Head/tail pair: pop shifts the tail forward, then a push lands in the
    // first free slot, so res_* always come straight from r_hd.
    always_comb begin
        w_n_hd     = r_hd;
        w_n_tl     = r_tl;
        w_n_hd_vld = r_hd_vld;
        w_n_tl_vld = r_tl_vld;
        if (w_res_pop) begin
            w_n_hd     = r_tl;
            w_n_hd_vld = r_tl_vld;
            w_n_tl_vld = 1'b0;
        end
        if (r_fl_vld) begin
            if (!w_n_hd_vld) begin
                w_n_hd     = w_res_new;
                w_n_hd_vld = 1'b1;
            end else begin
                w_n_tl     = w_res_new;
                w_n_tl_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr] <= '{a: in_a, b: in_b, tag: in_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_fl_vld <= 1'b0;
            r_fl_dz  <= 1'b0;
            r_fl_tag <= '0;
            r_rst_d  <= 1'b1;
            r_err    <= 1'b0;
            r_hd     <= '0;
            r_tl     <= '0;
            r_hd_vld <= 1'b0;
            r_tl_vld <= 1'b0;
        end else begin
            r_rst_d <= 1'b0;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_fl_vld <= w_issue;
            if (w_issue) begin
                r_fl_dz  <= w_head_dz;
                r_fl_tag <= w_head.tag;
            end
            r_hd     <= w_n_hd;
            r_tl     <= w_n_tl;
            r_hd_vld <= w_n_hd_vld;
            r_tl_vld <= w_n_tl_vld;
            // A result for a request issued before reset may still arrive in the
            // first cycle out of reset; it is not a protocol violation.
            if (!r_rst_d && (div_out_valid != (r_fl_vld && !r_fl_dz))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign res_valid = r_hd_vld;
    assign res_q     = r_hd.q;
    assign res_r     = r_hd.r;
    assign res_tag   = r_hd.tag;
    assign res_dz    = r_hd.dz;
    assign err       = r_err;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural 1-cycle divider attached.
module tb_div_sched;
    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [4:0]       in_b;
    logic [TAG_W-1:0] in_tag;
    logic [7:0]       div_a;
    logic [4:0]       div_b;
    logic             div_in_valid;
    logic [7:0]       div_q;
    logic [4:0]       div_r;
    logic             div_out_valid;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_q;
    logic [4:0]       res_r;
    logic [TAG_W-1:0] res_tag;
    logic             res_dz;
    logic             err;

    logic             force_ov = 1'b0;
    logic             m_ov = 1'b0;
    logic [7:0]       m_q = 8'd0;
    logic [4:0]       m_r = 5'd0;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] sa [16] = '{8'd200, 8'd55, 8'd255, 8'd0, 8'd17, 8'd99, 8'd128, 8'd31,
                            8'd250, 8'd7, 8'd64, 8'd13, 8'd255, 8'd100, 8'd1, 8'd180};
    logic [4:0] sb [16] = '{5'd7, 5'd0, 5'd31, 5'd1, 5'd0, 5'd10, 5'd3, 5'd5,
                            5'd0, 5'd8, 5'd16, 5'd13, 5'd2, 5'd0, 5'd31, 5'd11};

    div_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .div_a(div_a), .div_b(div_b), .div_in_valid(div_in_valid),
        .div_q(div_q), .div_r(div_r), .div_out_valid(div_out_valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_r(res_r),
        .res_tag(res_tag), .res_dz(res_dz), .err(err)
    );

    always #5 clk = ~clk;

    // Divider model: exactly one cycle of latency.
    always @(posedge clk) begin
        m_ov <= div_in_valid;
        if (div_in_valid && div_b != 5'd0) begin
            m_q <= div_a / {3'b000, div_b};
            m_r <= 5'(div_a % {3'b000, div_b});
        end
    end
    assign div_q         = m_q;
    assign div_r         = m_r;
    assign div_out_valid = m_ov | force_ov;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n;
        in_valid = 1'b0; in_a = 8'd0; in_b = 5'd0; in_tag = '0; res_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_div_vld", 32'(div_in_valid), 32'd0);
        chk("rst_res_vld", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_res_vld", 32'(res_valid), 32'd0);
        chk("post_rst_q", 32'(res_q), 32'd0);
        chk("post_rst_r", 32'(res_r), 32'd0);
        chk("post_rst_tag", 32'(res_tag), 32'd0);
        chk("post_rst_dz", 32'(res_dz), 32'd0);
        chk("post_rst_err", 32'(err), 32'd0);

        // single request: 200/7 = 28 r 4
        in_valid = 1'b1; in_a = 8'd200; in_b = 5'd7; in_tag = 3'd5;
        @(negedge clk); in_valid = 1'b0;
        chk("one_div_vld", 32'(div_in_valid), 32'd1);
        chk("one_div_a", 32'(div_a), 32'd200);
        chk("one_div_b", 32'(div_b), 32'd7);
        @(negedge clk);
        chk("one_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("one_vld", 32'(res_valid), 32'd1);
        chk("one_q", 32'(res_q), 32'd28);
        chk("one_r", 32'(res_r), 32'd4);
        chk("one_tag", 32'(res_tag), 32'd5);
        chk("one_dz", 32'(res_dz), 32'd0);

        // divide by zero
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'd55; in_b = 5'd0; in_tag = 3'd2;
        @(negedge clk); in_valid = 1'b0;
        chk("dz_div_vld", 32'(div_in_valid), 32'd0);
        @(negedge clk);
        chk("dz_early", 32'(res_valid), 32'd0);
        @(negedge clk);
        chk("dz_vld", 32'(res_valid), 32'd1);
        chk("dz_q", 32'(res_q), 32'hFF);
        chk("dz_r", 32'(res_r), 32'd0);
        chk("dz_tag", 32'(res_tag), 32'd2);
        chk("dz_dz", 32'(res_dz), 32'd1);
        chk("dz_err", 32'(err), 32'd0);

        // streaming, one result per cycle from cycle 3
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c < 16) begin
                in_valid = 1'b1; in_a = sa[c]; in_b = sb[c]; in_tag = 3'(c);
                chk("st_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            if (c >= 3 && c < 19) begin
                int k;
                k = c - 3;
                chk("st_vld", 32'(res_valid), 32'd1);
                chk("st_tag", 32'(res_tag), 32'(k % 8));
                chk("st_dz", 32'(res_dz), (sb[k] == 5'd0) ? 32'd1 : 32'd0);
                chk("st_q", 32'(res_q), (sb[k] == 5'd0) ? 32'hFF : 32'(sa[k] / sb[k]));
                chk("st_r", 32'(res_r), (sb[k] == 5'd0) ? 32'd0 : 32'(sa[k] % sb[k]));
            end else begin
                chk("st_idle", 32'(res_valid), 32'd0);
            end
        end

        // back-pressure: 2 buffered + DEPTH queued, then in_ready drops
        res_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = 8'(acc * 20 + 3); in_b = 5'(acc + 2); in_tag = 3'(acc);
            if (in_ready) acc++;
        end
        @(negedge clk); in_valid = 1'b0;
        chk("bp_accepts", 32'(acc), 32'(DEPTH + 2));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_res_vld", 32'(res_valid), 32'd1);
        chk("bp_hold_tag", 32'(res_tag), 32'd0);
        chk("bp_hold_q", 32'(res_q), 32'd1);
        res_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 24; c++) begin
            if (res_valid) begin
                chk("bp_tag", 32'(res_tag), 32'(n % 8));
                chk("bp_q", 32'(res_q), 32'((n * 20 + 3) / (n + 2)));
                chk("bp_r", 32'(res_r), 32'((n * 20 + 3) % (n + 2)));
                n++;
            end
            @(negedge clk);
        end
        chk("bp_drained", 32'(n), 32'(DEPTH + 2));

        // protocol error: spurious div_out_valid
        chk("pe_before", 32'(err), 32'd0);
        force_ov = 1'b1;
        @(negedge clk); force_ov = 1'b0;
        chk("pe_set", 32'(err), 32'd1);
        chk("pe_no_push", 32'(res_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("pe_sticky", 32'(err), 32'd1);

        // reset with 3 queued and 1 in flight
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_a = 8'(10 + k); in_b = 5'd3; in_tag = 3'(k);
            chk("mr_accept", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mr_rst_res_vld", 32'(res_valid), 32'd0);
        rst_n = 1'b0;
        force_ov = 1'b1;
        @(negedge clk); force_ov = 1'b0;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_res_vld", 32'(res_valid), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_q", 32'(res_q), 32'd0);
        res_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mr_quiet", 32'(res_valid), 32'd0);
        end
        in_valid = 1'b1; in_a = 8'd100; in_b = 5'd9; in_tag = 3'd7;
        @(negedge clk); in_valid = 1'b0;
        chk("mr_div_vld", 32'(div_in_valid), 32'd1);
        repeat (2) @(negedge clk);
        chk("mr_vld", 32'(res_valid), 32'd1);
        chk("mr_q2", 32'(res_q), 32'd11);
        chk("mr_r2", 32'(res_r), 32'd1);
        chk("mr_tag2", 32'(res_tag), 32'd7);
        chk("mr_dz2", 32'(res_dz), 32'd0);
        chk("mr_err2", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
